// File: rtl/fx3_stream_writer.sv
// fx3_stream_writer
//   Write-side engine for the FX3 synchronous slave FIFO, bound to one fixed
//   socket. It turns a 32-bit valid/ready word stream into FX3 write cycles.
//   It throttles on the partial-full flag, marks packet ends with PKEND, and
//   flushes a partially filled FX3 buffer after a period of idle time.
//
//   Ports
//     CLK, RESET         : clock and synchronous active-high reset
//     S_DATA/S_VALID/
//     S_LAST/S_READY     : upstream word stream; S_LAST ends a packet (PKEND)
//     DQ_OUT, DQ_OE      : FX3 data bus value and drive enable
//     ADDR               : FX3 socket address (constant ADDR_SEL)
//     SLCS_N, SLWR_N,
//     SLOE_N, PKEND_N    : FX3 strobes, active low (SLOE_N is held high)
//     FLAGA, FLAGB       : FX3 full / partial-full flags, active low
//     WORD_CNT           : running count of words written, wraps
//     ERR_FULL           : sticky, set if a write went out while full
module fx3_stream_writer #(
    parameter logic [1:0] ADDR_SEL      = 2'b00,
    parameter int          FLAG_LAT      = 3,
    parameter int          BUF_WORDS     = 1024,
    parameter int          FLUSH_TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] S_DATA,
    input  logic        S_VALID,
    input  logic        S_LAST,
    output logic        S_READY,
    output logic [31:0] DQ_OUT,
    output logic        DQ_OE,
    output logic [1:0]  ADDR,
    output logic        SLCS_N,
    output logic        SLWR_N,
    output logic        SLOE_N,
    output logic        PKEND_N,
    input  logic        FLAGA,
    input  logic        FLAGB,
    output logic [31:0] WORD_CNT,
    output logic        ERR_FULL
);

    localparam int SW = (FLAG_LAT > 1) ? $clog2(FLAG_LAT + 1) : 1;
    localparam int UW = $clog2(BUF_WORDS + 1);
    localparam int IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    // Idle timer fires on the cycle it would reach FLUSH_TIMEOUT and then
    // saturates, so an already-committed buffer never re-triggers a flush.
    localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);
    localparam logic [UW-1:0] UCNT_LAST = UW'(BUF_WORDS - 1);

    typedef enum logic [1:0] {SETTLE, STREAM, PAUSE, FLUSH} state_t;

    state_t        state_q;
    logic          fa_q, fb_q;
    logic [SW-1:0] settle_q;
    logic [UW-1:0] ucnt_q;
    logic [IW-1:0] idle_q;
    logic [31:0]   dq_q, wcnt_q;
    logic          slwr_n_q, pkend_n_q, slcs_n_q, dq_oe_q, err_q;

    logic hs, idle_hit;

    assign S_READY  = (state_q == STREAM) && fb_q;
    assign hs       = S_VALID && S_READY;
    assign idle_hit = (FLUSH_TIMEOUT != 0) && !hs && (idle_q == IDLE_LAST)
                      && (ucnt_q != '0);

    assign DQ_OUT   = dq_q;
    assign DQ_OE    = dq_oe_q;
    assign ADDR     = ADDR_SEL;
    assign SLCS_N   = slcs_n_q;
    assign SLWR_N   = slwr_n_q;
    assign SLOE_N   = 1'b1;
    assign PKEND_N  = pkend_n_q;
    assign WORD_CNT = wcnt_q;
    assign ERR_FULL = err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= SETTLE;
            fa_q      <= 1'b0;
            fb_q      <= 1'b0;
            settle_q  <= '0;
            ucnt_q    <= '0;
            idle_q    <= '0;
            dq_q      <= '0;
            wcnt_q    <= '0;
            slwr_n_q  <= 1'b1;
            pkend_n_q <= 1'b1;
            slcs_n_q  <= 1'b1;
            dq_oe_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            fa_q      <= FLAGA;
            fb_q      <= FLAGB;
            slcs_n_q  <= 1'b0;
            dq_oe_q   <= 1'b1;
            slwr_n_q  <= 1'b1;
            pkend_n_q <= 1'b1;
            idle_q    <= '0;

            case (state_q)
                SETTLE: begin
                    if (int'(settle_q) + 1 >= FLAG_LAT)
                        state_q <= fb_q ? STREAM : PAUSE;
                    else
                        settle_q <= settle_q + SW'(1);
                end
                STREAM: begin
                    if (hs) begin
                        dq_q      <= S_DATA;
                        slwr_n_q  <= 1'b0;
                        pkend_n_q <= ~S_LAST;
                        wcnt_q    <= wcnt_q + 32'd1;
                        // PKEND or the FX3's own auto-commit at BUF_WORDS
                        // both leave nothing pending.
                        ucnt_q    <= (S_LAST || ucnt_q == UCNT_LAST) ? '0
                                                                    : ucnt_q + UW'(1);
                        if (!fa_q)
                            err_q <= 1'b1;
                    end else if (idle_q != IDLE_MAX) begin
                        idle_q <= idle_q + IW'(1);
                    end else begin
                        idle_q <= idle_q;
                    end

                    if (!fb_q) begin
                        state_q <= PAUSE;
                        idle_q  <= '0;
                    end else if (idle_hit) begin
                        state_q <= FLUSH;
                        idle_q  <= '0;
                    end
                end
                PAUSE: begin
                    if (fb_q)
                        state_q <= STREAM;
                end
                FLUSH: begin
                    // Zero-length commit of whatever the FX3 is holding.
                    pkend_n_q <= 1'b0;
                    ucnt_q    <= '0;
                    state_q   <= STREAM;
                end
                default: state_q <= SETTLE;
            endcase
        end
    end

endmodule
